onehot_pulse_decoder: RTL
=========================

ONEHOT_PULSE_DECODER -- requirements
Module: onehot_pulse_decoder

Interface
REQ-001 Parameter DEPTH, default 4: code FIFO entries, power of two, 2..8.
REQ-002 Parameter HOLD, default 4: cycles each one-hot word is driven, 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 code  input  3  bit index to decode; bit value = 2**code.
REQ-006 code_none  input  1  when 1, entry decodes to all-zero word; code ignored.
REQ-007 code_valid  input  1  producer offers {code_none, code}.
REQ-008 code_ready  output  1  decoder can accept an entry this cycle.
REQ-009 onehot  output  8  registered decoded word.
REQ-010 active  output  1  high while a word (incl. all-zero) is being driven.
REQ-011 level  output  4  current FIFO occupancy, 0..DEPTH.

Function
REQ-012 Entry accepted at a rising edge iff code_valid and code_ready are both 1 in the preceding cycle.
REQ-013 code_ready = (level < DEPTH), combinational from registered level; no bypass when full, even if a pop occurs the same cycle.
REQ-014 Simultaneous push and pop: level unchanged; FIFO order preserved; write and read pointers wrap modulo DEPTH.
REQ-015 FSM states: IDLE, DRIVE, plus GAP only when DEC_GAP_EN is defined.
REQ-016 IDLE: onehot = 0, active = 0; if level > 0, pop head, load onehot, load hold counter with HOLD-1, go DRIVE at the same edge.
REQ-017 Latency: entry pushed into empty FIFO at edge N -> onehot valid and active = 1 after edge N+1.
REQ-018 DRIVE: onehot and active held exactly HOLD cycles; counter decrements each cycle.
REQ-019 DRIVE with counter = 0: if level > 0 and no gap configured, pop next entry and reload (back-to-back, no zero cycle); else go IDLE (or GAP), clearing onehot.
REQ-020 onehot has at most one bit set; code_none entries drive onehot = 0 with active = 1 for HOLD cycles.
REQ-021 HOLD = 1: each entry drives exactly one cycle; back-to-back entries change onehot every cycle.
REQ-022 Inputs while code_ready = 0 are ignored; no state change, no error flag.

Reset
REQ-023 While rst = 1: onehot = 0, active = 0, level = 0, code_ready = 1 (DEPTH >= 1 satisfied), FSM = IDLE, pointers and counter = 0.
REQ-024 Reset asserted mid-DRIVE aborts immediately (asynchronously); queued entries discarded; FIFO storage contents need not clear.
REQ-025 First accept possible at first rising edge after rst deasserts.

Configuration
REQ-026 Macro DEC_GAP_EN: when defined, every DRIVE ending enters GAP for exactly one cycle (onehot = 0, active = 0) before the next pop; GAP then behaves as IDLE.
REQ-027 Without DEC_GAP_EN: GAP state absent; back-to-back per REQ-019.

Verification
REQ-028 Reset, push code=5 once, HOLD=4 -> onehot = 0x20, active = 1 for exactly 4 cycles starting one cycle after accept, then 0x00.
REQ-029 Push codes 0,7,3 consecutively, HOLD=2, no macro -> onehot sequence 0x01,0x01,0x80,0x80,0x08,0x08, then 0x00; level peaks at 2.
REQ-030 Same stimulus with DEC_GAP_EN -> 0x01,0x01,0x00,0x80,0x80,0x00,0x08,0x08; active low on gap cycles.
REQ-031 Hold code_valid high with DEPTH=4, HOLD=8 -> level reaches 4, code_ready = 0, fifth offer not accepted until first pop.
REQ-032 Push code_none=1 -> onehot = 0x00 with active = 1 for HOLD cycles.
REQ-033 Assert rst during DRIVE with level = 3 -> onehot = 0, active = 0, level = 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: queues 3-bit codes in a small FIFO and drives each one
// as a registered one-hot word for HOLD cycles.
// Optional build macro DEC_GAP_EN inserts one idle GAP cycle after every DRIVE.
module onehot_pulse_decoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLD  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code,
    input  logic       code_none,
    input  logic       code_valid,
    output logic       code_ready,
    output logic [7:0] onehot,
    output logic       active,
    output logic [3:0] level
);

    localparam int unsigned PW          = $clog2(DEPTH);
    localparam logic [7:0]  HOLD_RELOAD = 8'(HOLD - 1);

`ifdef DEC_GAP_EN
    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DRIVE} state_t;
`endif

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      onehot_q, onehot_d;
    logic [3:0]      level_q, level_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]      mem_q [DEPTH];

    logic            push;
    logic            pop;
    logic [3:0]      head;
    logic [7:0]      head_word;

    assign push      = code_valid && code_ready;
    assign head      = mem_q[rd_ptr_q];
    assign head_word = head[3] ? 8'h00 : (8'h01 << head[2:0]);

    // State register plus FIFO bookkeeping; reset aborts everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are don't-care after reset so no reset term
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {code_none, code};
        end
    end

    // Next-state: pop the head and load the hold counter whenever a new word starts
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop      = 1'b1;
                    onehot_d = head_word;
                    cnt_d    = HOLD_RELOAD;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
`ifdef DEC_GAP_EN
                    state_d  = GAP;
                    onehot_d = '0;
`else
                    if (level_q != '0) begin
                        pop      = 1'b1;
                        onehot_d = head_word;
                        cnt_d    = HOLD_RELOAD;
                    end else begin
                        state_d  = IDLE;
                        onehot_d = '0;
                    end
`endif
                end
            end
`ifdef DEC_GAP_EN
            GAP: begin
                if (level_q != '0) begin
                    pop      = 1'b1;
                    onehot_d = head_word;
                    cnt_d    = HOLD_RELOAD;
                    state_d  = DRIVE;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d  = IDLE;
                onehot_d = '0;
            end
        endcase
    end

    // FIFO pointer and occupancy update; simultaneous push and pop keeps level
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 4'd1;
        end else if (!push && pop) begin
            level_d = level_q - 4'd1;
        end
    end

    // Outputs: ready from registered level only, active tracks the DRIVE state
    always_comb begin
        code_ready = (level_q < 4'(DEPTH));
        active     = (state_q == DRIVE);
        onehot     = onehot_q;
        level      = level_q;
    end

endmodule
